// File: rtl/uart_async_transmitter_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_async_transmitter_if
//  Brief    : User-side byte/strobe handshake and serial line of the UART TX.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_async_transmitter_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       UART_TXD;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  UART_TXD,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output UART_TXD,
    output tx_busy,
    output tx_done
  );
endinterface : uart_async_transmitter_if
`default_nettype wire

// File: rtl/uart_async_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_async_transmitter
//  Brief    : 8N1 UART transmitter with a per-frame bit-period divider.
//             Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_async_transmitter #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200
) (
  input  wire logic               CLOCK_50,
  input  wire logic               rst_n,
  uart_async_transmitter_if.slave tx_if
);

  localparam int BitClks = ClkFrequency / Baud;
  localparam int DIV_W   = (BitClks > 1) ? $clog2(BitClks) : 1;

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(BitClks - 1);
  localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } state_t;
`endif

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bitcnt;
  logic             r_txd;
  logic             r_busy;
  logic             r_done;
`ifdef UART_TX_PARITY_EN
  logic             r_parity;
`endif

  logic w_bit_end;
  assign w_bit_end = (r_div == c_div_last);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE) begin
        r_div <= w_bit_end ? '0 : r_div + c_div_one;
      end

      // r_txd is loaded one cycle ahead so the line changes exactly on bit boundaries
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
          if (tx_if.tx_start) begin
            r_shift  <= tx_if.tx_data;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
            r_txd    <= 1'b0;
            r_state  <= ST_START;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^tx_if.tx_data;
`endif
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_txd   <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_shift  <= r_shift >> 1;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_txd   <= r_parity;
              r_state <= ST_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              r_txd <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_txd   <= 1'b1;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_if.UART_TXD = r_txd;
  assign tx_if.tx_busy  = r_busy;
  assign tx_if.tx_done  = r_done;

endmodule : uart_async_transmitter
`default_nettype wire

// File: tb/tb_uart_async_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_async_transmitter
//  Brief    : Directed self-checking bench, ClkFrequency=1000 / Baud=100.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_async_transmitter;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;
  int   vectors  = 0;
  int   fails    = 0;
  int   cyc      = 0;

  uart_async_transmitter_if tx_if ();

  uart_async_transmitter #(
    .ClkFrequency (1000),
    .Baud         (100)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .tx_if    (tx_if.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_if.tx_start = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) tick();
    vectors++;
    if (tx_if.UART_TXD !== 1'b1 || tx_if.tx_busy !== 1'b0 || tx_if.tx_done !== 1'b0) begin
      fails++;
      $display("FAIL reset: txd=%b busy=%b done=%b, want 1 0 0",
               tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      vectors++;
      if (tx_if.UART_TXD !== 1'b1 || tx_if.tx_busy !== 1'b0 || tx_if.tx_done !== 1'b0) begin
        fails++;
        $display("FAIL idle_after_reset k=%0d: txd=%b busy=%b done=%b, want 1 0 0",
                 k, tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done);
      end
    end
  endtask

`ifndef UART_TX_PARITY_EN
  task automatic test_single();
    logic [9:0] exp_line;
    exp_line = 10'h2AA;  // 0x55: 0,1,0,1,0,1,0,1,0,1
    tx_if.tx_data  = 8'h55;
    tx_if.tx_start = 1'b1;
    tick();
    tx_if.tx_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      vectors++;
      if (tx_if.UART_TXD !== exp_line[k/10] || tx_if.tx_busy !== 1'b1 || tx_if.tx_done !== 1'b0) begin
        fails++;
        $display("FAIL single k=%0d: txd=%b busy=%b done=%b, want %b 1 0",
                 k, tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done, exp_line[k/10]);
      end
      tick();
    end
    vectors++;
    if (tx_if.UART_TXD !== 1'b1 || tx_if.tx_busy !== 1'b0 || tx_if.tx_done !== 1'b1) begin
      fails++;
      $display("FAIL single_end: txd=%b busy=%b done=%b, want 1 0 1",
               tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done);
    end
    tick();
    vectors++;
    if (tx_if.tx_done !== 1'b0) begin
      fails++;
      $display("FAIL single_done_pulse: done=%b, want 0", tx_if.tx_done);
    end
  endtask

  task automatic test_ignore_busy();
    logic [9:0] exp_line;
    exp_line = 10'h346;  // 0xA3: 0, 1,1,0,0,0,1,0,1, 1
    tx_if.tx_data  = 8'hA3;
    tx_if.tx_start = 1'b1;
    tick();
    tx_if.tx_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      vectors++;
      if (tx_if.UART_TXD !== exp_line[k/10] || tx_if.tx_busy !== 1'b1 || tx_if.tx_done !== 1'b0) begin
        fails++;
        $display("FAIL ignore_busy k=%0d: txd=%b busy=%b done=%b, want %b 1 0",
                 k, tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done, exp_line[k/10]);
      end
      if (k == 35) begin
        tx_if.tx_data  = 8'hFF;
        tx_if.tx_start = 1'b1;
      end else begin
        tx_if.tx_start = 1'b0;
      end
      tick();
    end
    vectors++;
    if (tx_if.tx_done !== 1'b1 || tx_if.tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_busy_end: done=%b busy=%b, want 1 0", tx_if.tx_done, tx_if.tx_busy);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (tx_if.UART_TXD !== 1'b1 || tx_if.tx_busy !== 1'b0 || tx_if.tx_done !== 1'b0) begin
        fails++;
        $display("FAIL ignore_busy_no_queue k=%0d: txd=%b busy=%b done=%b, want 1 0 0",
                 k, tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_a;
    logic [9:0] exp_b;
    int         t_done1;
    int         t_done2;
    exp_a   = 10'h200;  // 0x00
    exp_b   = 10'h3FE;  // 0xFF
    t_done1 = -1;
    t_done2 = -1;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_start = 1'b1;
    tick();
    tx_if.tx_data = 8'hFF;
    for (int k = 0; k < 100; k++) begin
      vectors++;
      if (tx_if.UART_TXD !== exp_a[k/10] || tx_if.tx_busy !== 1'b1) begin
        fails++;
        $display("FAIL b2b_frame1 k=%0d: txd=%b busy=%b, want %b 1",
                 k, tx_if.UART_TXD, tx_if.tx_busy, exp_a[k/10]);
      end
      tick();
    end
    vectors++;
    if (tx_if.UART_TXD !== 1'b1 || tx_if.tx_busy !== 1'b0 || tx_if.tx_done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle_gap: txd=%b busy=%b done=%b, want 1 0 1",
               tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done);
    end
    if (tx_if.tx_done === 1'b1) t_done1 = cyc;
    tick();
    for (int k = 0; k < 100; k++) begin
      vectors++;
      if (tx_if.UART_TXD !== exp_b[k/10] || tx_if.tx_busy !== 1'b1 || tx_if.tx_done !== 1'b0) begin
        fails++;
        $display("FAIL b2b_frame2 k=%0d: txd=%b busy=%b done=%b, want %b 1 0",
                 k, tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done, exp_b[k/10]);
      end
      tx_if.tx_start = 1'b0;
      tick();
    end
    if (tx_if.tx_done === 1'b1) t_done2 = cyc;
    vectors++;
    if (t_done1 < 0 || t_done2 < 0 || (t_done2 - t_done1) !== 101) begin
      fails++;
      $display("FAIL b2b_done_spacing: done1=%0d done2=%0d, want spacing 101",
               t_done1, t_done2);
    end
  endtask

  task automatic test_mid_reset();
    logic [9:0] exp_line;
    exp_line = 10'h278;  // 0x3C: 0, 0,0,1,1,1,1,0,0, 1
    tx_if.tx_data  = 8'h00;
    tx_if.tx_start = 1'b1;
    tick();
    tx_if.tx_start = 1'b0;
    repeat (47) tick();
    vectors++;
    if (tx_if.UART_TXD !== 1'b0 || tx_if.tx_busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_pre: txd=%b busy=%b, want 0 1", tx_if.UART_TXD, tx_if.tx_busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tx_if.UART_TXD !== 1'b1 || tx_if.tx_busy !== 1'b0 || tx_if.tx_done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_async: txd=%b busy=%b done=%b, want 1 0 0",
               tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if (tx_if.UART_TXD !== 1'b1 || tx_if.tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_no_resume: txd=%b busy=%b, want 1 0", tx_if.UART_TXD, tx_if.tx_busy);
    end
    tx_if.tx_data  = 8'h3C;
    tx_if.tx_start = 1'b1;
    tick();
    tx_if.tx_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      vectors++;
      if (tx_if.UART_TXD !== exp_line[k/10] || tx_if.tx_busy !== 1'b1 || tx_if.tx_done !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_frame k=%0d: txd=%b busy=%b done=%b, want %b 1 0",
                 k, tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done, exp_line[k/10]);
      end
      tick();
    end
    vectors++;
    if (tx_if.tx_done !== 1'b1 || tx_if.tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_done: done=%b busy=%b, want 1 0", tx_if.tx_done, tx_if.tx_busy);
    end
    tick();
  endtask
`else
  task automatic test_parity();
    logic [7:0]  data_v [2];
    logic [10:0] exp_v  [2];
    data_v[0] = 8'h07;  exp_v[0] = 11'h60E;  // parity 1
    data_v[1] = 8'h03;  exp_v[1] = 11'h406;  // parity 0
    for (int f = 0; f < 2; f++) begin
      tx_if.tx_data  = data_v[f];
      tx_if.tx_start = 1'b1;
      tick();
      tx_if.tx_start = 1'b0;
      for (int k = 0; k < 110; k++) begin
        vectors++;
        if (tx_if.UART_TXD !== exp_v[f][k/10] || tx_if.tx_busy !== 1'b1 || tx_if.tx_done !== 1'b0) begin
          fails++;
          $display("FAIL parity data=%h k=%0d: txd=%b busy=%b done=%b, want %b 1 0",
                   data_v[f], k, tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done, exp_v[f][k/10]);
        end
        tick();
      end
      vectors++;
      if (tx_if.tx_done !== 1'b1 || tx_if.tx_busy !== 1'b0 || tx_if.UART_TXD !== 1'b1) begin
        fails++;
        $display("FAIL parity_end data=%h: txd=%b busy=%b done=%b, want 1 0 1",
                 data_v[f], tx_if.UART_TXD, tx_if.tx_busy, tx_if.tx_done);
      end
      tick();
    end
  endtask
`endif

  initial begin
    tx_if.tx_start = 1'b0;
    tx_if.tx_data  = 8'h00;
    test_reset();
`ifndef UART_TX_PARITY_EN
    test_single();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
`else
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule : tb_uart_async_transmitter
`default_nettype wire

// File: doc/uart_async_transmitter.md
Name: uart_async_transmitter

Overview:
- 8N1 UART transmitter. Serialises a parallel byte onto UART_TXD.
- Counterpart of the board's async UART receiver, using the same ClkFrequency/Baud parameter scheme.
- Sits between user logic (byte + start strobe) and the board TX pin.
- Self-contained bit-period divider, restarted at each frame, so bit edges align exactly to frame start.

Parameters:
- ClkFrequency, 50000000, system clock frequency in Hz.
- Baud, 115200, line rate in bits/s.
- BitClks = ClkFrequency/Baud (localparam, integer division): clocks per bit, must be >= 2. Default is 434.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_start  input  1  one-cycle or level request; sampled only while idle.
- tx_data  input  8  byte to send; captured in the cycle tx_start is accepted.
- UART_TXD  output  1  serial line, idles high.
- tx_busy  output  1  high from the cycle after acceptance until the stop bit completes.
- tx_done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (rst_n low, any time, including mid-frame):
  - state=IDLE, UART_TXD=1, tx_busy=0, tx_done=0.
  - Shift register=0, divider=0, bit counter=0.
  - An aborted frame is not resumed.
- States: IDLE, START, DATA, STOP (PARITY is added only when the optional feature is compiled in).
- IDLE:
  - UART_TXD=1.
  - If tx_start=1 on a clock edge: latch tx_data into an 8-bit shift register, clear divider and bit counter, go to START.
  - tx_busy=1 from that edge.
- Divider: counts 0..BitClks-1 in every non-IDLE state; bit_end asserts when divider==BitClks-1, then the divider wraps to 0.
- START: UART_TXD=0 for exactly BitClks cycles; on bit_end go to DATA.
- DATA:
  - UART_TXD = shift_reg[0] (LSB first).
  - On bit_end: shift right by one, bit counter +1.
  - After 8 bits (bit_end with counter==7), go to STOP (or PARITY).
- STOP:
  - UART_TXD=1 for BitClks cycles.
  - On bit_end: go to IDLE, pulse tx_done=1 for one cycle, tx_busy=0 on that same edge.
- Frame length: exactly 10*BitClks clocks from the first START cycle to the return to IDLE (11*BitClks with parity).
- Latency: the first START-bit cycle on UART_TXD is the cycle immediately after the tx_start acceptance edge.
- tx_start while busy is ignored: no queueing, no frame corruption. tx_data changes mid-frame have no effect.
- Back-to-back:
  - tx_start held high continuously is re-accepted in the first IDLE cycle after STOP.
  - That gives one IDLE cycle (line high) between frames, in addition to the full stop bit.
- UART_TXD is driven from a register, so there is no combinational glitch path from the state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits even parity (XOR of the 8 latched data bits) for BitClks cycles.
  - Frame length becomes 11*BitClks.
- Undefined: no PARITY state and no parity logic; frame is 8N1, 10*BitClks.

Test Plan (ClkFrequency=1000, Baud=100, so BitClks=10):
- Reset: rst_n=0 -> UART_TXD=1, tx_busy=0, tx_done=0. Release reset with no tx_start -> line stays 1 for 100 cycles.
- Single frame: tx_data=8'h55, tx_start pulse.
  - Line, 10 cycles per bit: 0,1,0,1,0,1,0,1,0,1.
  - tx_busy high for 100 cycles, then tx_done pulses once at cycle 100.
- Ignore while busy: send 8'hA3, then pulse tx_start with tx_data=8'hFF at cycle 35.
  - Received bits are exactly A3 LSB-first (1,1,0,0,0,1,0,1) plus stop; only one tx_done.
- Back-to-back: hold tx_start=1 with 8'h00 then 8'hFF.
  - Two complete frames; exactly 1 idle-high cycle between stop and next start; two tx_done pulses 101 cycles apart.
- Mid-frame reset: assert rst_n=0 at cycle 47 of a frame.
  - Same cycle (asynchronous): UART_TXD=1, tx_busy=0.
  - After release, the next tx_start of 8'h3C produces a clean full frame.
- UART_TX_PARITY_EN defined:
  - 8'h07 -> parity bit 1.
  - 8'h03 -> parity bit 0.
  - Frame length 110 cycles; tx_done at cycle 110.
